ycr_dmem_sram_resp: RTL
=======================

# ycr_dmem_sram_resp

Data-memory responder: terminates one downstream port of the dmem router with the dmem request/response protocol on the core side and a single-port synchronous SRAM macro on the memory side. It accepts one request at a time, checks width/alignment/burst legality, performs byte-lane masking for writes and right-alignment for reads, and returns per-beat responses with last-beat signalling (`YCR_MEM_RESP_RDY_LOK`). It sits between a router port (e.g. port1/port2) and a local data SRAM.

## Interface
- `MEM_AWIDTH`, 9, SRAM word-address width (depth = 2^MEM_AWIDTH words)
- `clk`  in  1  core clock
- `rst`  in  1  reset, synchronous, active-high
- `dmem_req`  in  1  request valid
- `dmem_cmd`  in  1  `YCR_MEM_CMD_RD`/`YCR_MEM_CMD_WR`
- `dmem_bl`  in  `YCR_IMEM_BSIZE`  burst length in beats
- `dmem_width`  in  2  byte/hword/word/error
- `dmem_addr`  in  `YCR_DMEM_AWIDTH`  byte address
- `dmem_wdata`  in  `YCR_DMEM_DWIDTH`  write data, right-aligned
- `dmem_req_ack`  out  1  request accepted this cycle (with `dmem_req`)
- `dmem_rdata`  out  `YCR_DMEM_DWIDTH`  read data, right-aligned
- `dmem_resp`  out  2  NOTRDY / RDY_OK / RDY_ER / RDY_LOK
- `sram_csb`  out  1  chip select, active-low
- `sram_web`  out  1  write enable, active-low
- `sram_wmask`  out  4  byte write mask
- `sram_addr`  out  MEM_AWIDTH  word address
- `sram_din`  out  32  write data, lane-replicated
- `sram_dout`  in  32  read data, valid one cycle after read select

## Operation
- FSM: IDLE, RD, WR, ERR.
- IDLE: `dmem_req_ack`=1. On `dmem_req`: capture cmd/width/addr/wdata/bl; legality check picks next state.
- Illegal (→ERR): width==`YCR_MEM_WIDTH_ERROR`; hword with addr[0]=1; word with addr[1:0]≠0; bl==0; write with bl≠1.
- ERR: `dmem_resp`=RDY_ER for one cycle, no SRAM access, →IDLE.
- WR: one SRAM write (csb=0, web=0); wmask byte=1<<addr[1:0], hword=4'b0011<<addr[1:0], word=4'hF; din replicates byte ×4 / hword ×2. Resp RDY_LOK same cycle, →IDLE.
- RD: issue bl reads on consecutive cycles, word address starting at addr[MEM_AWIDTH+1:2], +1 per beat, wrap modulo 2^MEM_AWIDTH. Beat counter counts issued beats; a second counter counts returned beats.
- Read data: `sram_dout` shifted right by 8×addr[1:0] (first beat only; later beats word-aligned, offset 0), masked to width, upper bits zero (no sign extension). Non-last beats RDY_OK, last RDY_LOK, then →IDLE.
- Outside response cycles `dmem_resp`=NOTRDY, `dmem_rdata`=0.
- `dmem_req_ack`=0 in RD/WR/ERR; requests held off, not dropped.

## Timing
- Reset (rst=1 at edge): state IDLE, `dmem_req_ack`=0 while rst high, `dmem_resp`=NOTRDY, `dmem_rdata`=0, `sram_csb`=1, `sram_web`=1, `sram_wmask`=0, `sram_addr`=0, `sram_din`=0.
- Accept at cycle T. Write: SRAM write + RDY_LOK at T+1, ack again at T+2.
- Read bl=N: SRAM selects T+1..T+N; beat k response at T+2+k (k=0..N-1); RDY_LOK at T+N+1; ack at T+N+2.
- Error: RDY_ER at T+1; ack at T+2.
- Wrap: beat addr = 2^MEM_AWIDTH−1 followed by 0, no error.
- Reset mid-burst: remaining beats abandoned, no further resp, `sram_csb`=1 from the next cycle.
- SRAM outputs registered; `dmem_rdata`/`dmem_resp` combinational from `sram_dout` and state registers.

## Configuration
- `YCR_DMEM_RESP_BURST_EN` defined: read bursts bl≥1 as above.
- Not defined: only bl==1 legal for reads; bl≠1 → RDY_ER; beat counters removed; single read returns RDY_LOK at T+2.

## Structure
- Cmd/width/resp encodings come from the shared `ycr_memif.svh` definitions; no new shared constants. FSM enum stays local.
- One sub-module: `ycr_dmem_lane_align` (combinational): wmask/din replication for writes, shift/mask for reads.

## Test plan
- Word write 0x1234_5678 @0x10 then word read @0x10 → wmask 4'hF, sram_addr 4; read RDY_LOK at T+2, rdata 0x1234_5678.
- Byte write 0xAB @0x13, read byte @0x13 → wmask 4'b1000, din 0xABABABAB; rdata 0x0000_00AB.
- Hword read @0x01 → RDY_ER at T+1, sram_csb stays 1; width=2'b11 → RDY_ER.
- (BURST_EN) read bl=4 @0x7F8 with MEM_AWIDTH=9 → sram_addr 510,511,0,1; resp OK,OK,OK,LOK at T+2..T+5; ack low until T+6.
- (no BURST_EN) read bl=4 → RDY_ER; write bl=2 → RDY_ER in both builds.
- Assert rst at beat 2 of bl=4 burst → no further resp, csb=1 next cycle, ack=1 the cycle after rst drops.

Source files
------------

// File: rtl/ycr_dmem_sram_resp_pkg.sv
// rtl/ycr_dmem_sram_resp_pkg.sv - dmem interface encodings and widths (ycr_memif values) for the SRAM responder
package ycr_dmem_sram_resp_pkg;
    localparam int YCR_IMEM_BSIZE  = 3;
    localparam int YCR_DMEM_AWIDTH = 32;
    localparam int YCR_DMEM_DWIDTH = 32;

    localparam logic       YCR_MEM_CMD_RD = 1'b0;
    localparam logic       YCR_MEM_CMD_WR = 1'b1;

    localparam logic [1:0] YCR_MEM_WIDTH_BYTE  = 2'b00;
    localparam logic [1:0] YCR_MEM_WIDTH_HWORD = 2'b01;
    localparam logic [1:0] YCR_MEM_WIDTH_WORD  = 2'b10;
    localparam logic [1:0] YCR_MEM_WIDTH_ERROR = 2'b11;

    localparam logic [1:0] YCR_MEM_RESP_NOTRDY  = 2'b00;
    localparam logic [1:0] YCR_MEM_RESP_RDY_OK  = 2'b01;
    localparam logic [1:0] YCR_MEM_RESP_RDY_ER  = 2'b10;
    localparam logic [1:0] YCR_MEM_RESP_RDY_LOK = 2'b11;

    function automatic logic [31:0] width_mask(input logic [1:0] width);
        case (width)
            YCR_MEM_WIDTH_BYTE:  return 32'h0000_00FF;
            YCR_MEM_WIDTH_HWORD: return 32'h0000_FFFF;
            default:             return 32'hFFFF_FFFF;
        endcase
    endfunction
endpackage

// File: rtl/ycr_dmem_sram_resp_if.sv
// rtl/ycr_dmem_sram_resp_if.sv - dmem request/response bundle; master = router side, slave = responder
interface ycr_dmem_sram_resp_if;
    import ycr_dmem_sram_resp_pkg::*;

    logic                       dmem_req;
    logic                       dmem_cmd;
    logic [YCR_IMEM_BSIZE-1:0]  dmem_bl;
    logic [1:0]                 dmem_width;
    logic [YCR_DMEM_AWIDTH-1:0] dmem_addr;
    logic [YCR_DMEM_DWIDTH-1:0] dmem_wdata;
    logic                       dmem_req_ack;
    logic [YCR_DMEM_DWIDTH-1:0] dmem_rdata;
    logic [1:0]                 dmem_resp;

    modport master (
        output dmem_req, dmem_cmd, dmem_bl, dmem_width, dmem_addr, dmem_wdata,
        input  dmem_req_ack, dmem_rdata, dmem_resp
    );

    modport slave (
        input  dmem_req, dmem_cmd, dmem_bl, dmem_width, dmem_addr, dmem_wdata,
        output dmem_req_ack, dmem_rdata, dmem_resp
    );
endinterface

// File: rtl/ycr_dmem_lane_align.sv
// rtl/ycr_dmem_lane_align.sv - byte-lane mask/replication for writes, shift/mask right-alignment for reads
module ycr_dmem_lane_align
    import ycr_dmem_sram_resp_pkg::*;
(
    input  logic [1:0]  wr_width,
    input  logic [1:0]  wr_off,
    input  logic [31:0] wdata,
    output logic [3:0]  wmask,
    output logic [31:0] din,
    input  logic [1:0]  rd_width,
    input  logic [1:0]  rd_off,
    input  logic [31:0] rword,
    output logic [31:0] rdata
);
    always_comb begin
        wmask = 4'b0000;
        din   = wdata;
        case (wr_width)
            YCR_MEM_WIDTH_BYTE: begin
                wmask = 4'b0001 << wr_off;
                din   = {4{wdata[7:0]}};
            end
            YCR_MEM_WIDTH_HWORD: begin
                wmask = 4'b0011 << wr_off;
                din   = {2{wdata[15:0]}};
            end
            YCR_MEM_WIDTH_WORD: wmask = 4'hF;
            default: ;
        endcase
    end

    // Zero-extended: upper bits cleared by the width mask, no sign extension
    assign rdata = (rword >> {rd_off, 3'b000}) & width_mask(rd_width);
endmodule

// File: rtl/ycr_dmem_sram_resp.sv
// rtl/ycr_dmem_sram_resp.sv - dmem router port to single-port SRAM responder; YCR_DMEM_RESP_BURST_EN enables read bursts
module ycr_dmem_sram_resp
    import ycr_dmem_sram_resp_pkg::*;
#(
    parameter int MEM_AWIDTH = 9
)(
    input  logic                  clk,
    input  logic                  rst,
    ycr_dmem_sram_resp_if.slave   dmem,
    output logic                  sram_csb,
    output logic                  sram_web,
    output logic [3:0]            sram_wmask,
    output logic [MEM_AWIDTH-1:0] sram_addr,
    output logic [31:0]           sram_din,
    input  logic [31:0]           sram_dout
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    logic [1:0]  state;
    logic [1:0]  rd_width;
    logic [1:0]  rd_off;
    logic        resp_vld;
    logic        req_legal;
    logic        first_beat;
    logic        last_beat;
    logic [3:0]  lane_wmask;
    logic [31:0] lane_din;
    logic [31:0] lane_rdata;
    logic        unused_addr;

    assign unused_addr = ^dmem.dmem_addr[YCR_DMEM_AWIDTH-1:MEM_AWIDTH+2];

`ifdef YCR_DMEM_RESP_BURST_EN
    logic [YCR_IMEM_BSIZE-1:0] bl_r;
    logic [YCR_IMEM_BSIZE-1:0] iss_cnt;
    logic [YCR_IMEM_BSIZE-1:0] ret_cnt;

    assign first_beat = (ret_cnt == '0);
    assign last_beat  = (ret_cnt == bl_r - YCR_IMEM_BSIZE'(1));
`else
    assign first_beat = 1'b1;
    assign last_beat  = 1'b1;
`endif

    always_comb begin
        req_legal = 1'b1;
        case (dmem.dmem_width)
            YCR_MEM_WIDTH_BYTE:  ;
            YCR_MEM_WIDTH_HWORD: if (dmem.dmem_addr[0]) req_legal = 1'b0;
            YCR_MEM_WIDTH_WORD:  if (dmem.dmem_addr[1:0] != 2'b00) req_legal = 1'b0;
            default:             req_legal = 1'b0;
        endcase
        if (dmem.dmem_bl == '0) req_legal = 1'b0;
`ifdef YCR_DMEM_RESP_BURST_EN
        if (dmem.dmem_cmd == YCR_MEM_CMD_WR && dmem.dmem_bl != YCR_IMEM_BSIZE'(1)) req_legal = 1'b0;
`else
        if (dmem.dmem_bl != YCR_IMEM_BSIZE'(1)) req_legal = 1'b0;
`endif
    end

    ycr_dmem_lane_align u_lane_align (
        .wr_width (dmem.dmem_width),
        .wr_off   (dmem.dmem_addr[1:0]),
        .wdata    (dmem.dmem_wdata),
        .wmask    (lane_wmask),
        .din      (lane_din),
        .rd_width (rd_width),
        .rd_off   (first_beat ? rd_off : 2'b00),
        .rword    (sram_dout),
        .rdata    (lane_rdata)
    );

    // resp_vld marks the cycle where sram_dout holds the previous cycle's read
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            sram_csb   <= 1'b1;
            sram_web   <= 1'b1;
            sram_wmask <= 4'b0000;
            sram_addr  <= '0;
            sram_din   <= '0;
            resp_vld   <= 1'b0;
            rd_width   <= 2'b00;
            rd_off     <= 2'b00;
`ifdef YCR_DMEM_RESP_BURST_EN
            bl_r       <= '0;
            iss_cnt    <= '0;
            ret_cnt    <= '0;
`endif
        end else begin
            sram_csb   <= 1'b1;
            sram_web   <= 1'b1;
            sram_wmask <= 4'b0000;
            resp_vld   <= 1'b0;
            case (state)
                ST_IDLE: if (dmem.dmem_req) begin
                    if (!req_legal) begin
                        state <= ST_ERR;
                    end else if (dmem.dmem_cmd == YCR_MEM_CMD_WR) begin
                        state      <= ST_WR;
                        sram_csb   <= 1'b0;
                        sram_web   <= 1'b0;
                        sram_wmask <= lane_wmask;
                        sram_addr  <= dmem.dmem_addr[MEM_AWIDTH+1:2];
                        sram_din   <= lane_din;
                    end else begin
                        state     <= ST_RD;
                        sram_csb  <= 1'b0;
                        sram_addr <= dmem.dmem_addr[MEM_AWIDTH+1:2];
                        rd_width  <= dmem.dmem_width;
                        rd_off    <= dmem.dmem_addr[1:0];
`ifdef YCR_DMEM_RESP_BURST_EN
                        bl_r      <= dmem.dmem_bl;
                        iss_cnt   <= YCR_IMEM_BSIZE'(1);
                        ret_cnt   <= '0;
`endif
                    end
                end
                ST_RD: begin
                    resp_vld <= ~sram_csb;
`ifdef YCR_DMEM_RESP_BURST_EN
                    if (iss_cnt != bl_r) begin
                        sram_csb  <= 1'b0;
                        sram_addr <= sram_addr + MEM_AWIDTH'(1);
                        iss_cnt   <= iss_cnt + YCR_IMEM_BSIZE'(1);
                    end
                    if (resp_vld) begin
                        ret_cnt <= ret_cnt + YCR_IMEM_BSIZE'(1);
                        if (last_beat) state <= ST_IDLE;
                    end
`else
                    if (resp_vld) state <= ST_IDLE;
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        dmem.dmem_req_ack = (state == ST_IDLE) && !rst;
        dmem.dmem_resp    = YCR_MEM_RESP_NOTRDY;
        dmem.dmem_rdata   = '0;
        if (!rst) begin
            case (state)
                ST_WR:  dmem.dmem_resp = YCR_MEM_RESP_RDY_LOK;
                ST_ERR: dmem.dmem_resp = YCR_MEM_RESP_RDY_ER;
                ST_RD: if (resp_vld) begin
                    dmem.dmem_resp  = last_beat ? YCR_MEM_RESP_RDY_LOK : YCR_MEM_RESP_RDY_OK;
                    dmem.dmem_rdata = lane_rdata;
                end
                default: ;
            endcase
        end
    end
endmodule
